// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared constants for the CPU clock controller: FSM state encoding and debounce default.
package cpu_clk_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_STEP = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_HALT = 2'd2;

    localparam int unsigned DEB_CYCLES_DEFAULT = 500000;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, debounced level and a
// one-cycle press pulse on the debounced 0->1 transition.
module btn_debounce
    import cpu_clk_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic            sync1_q;
    logic            sync2_q;
    logic            level_q;
    logic            press_q;
    logic [CntW-1:0] cnt_q;
    logic            mismatch;
    logic            done;

    assign mismatch = (sync2_q != level_q);
    // Level flips on the DEB_CYCLES-th consecutive mismatching cycle.
    assign done     = mismatch && (cnt_q == CntW'(DEB_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (done) begin
                level_q <= sync2_q;
                press_q <= sync2_q;
                cnt_q   <= '0;
            end else if (mismatch) begin
                cnt_q   <= cnt_q + CntW'(1);
            end else begin
                cnt_q   <= '0;
            end
        end
    end

    assign press = press_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU advance controller: free-run from slow_clk ticks, single-step from a button, halt/resume.
// Optional cpu_en pulse counter enabled by defining CPU_CLK_CTRL_CYCLE_CNT_EN.
module cpu_clk_ctrl
    import cpu_clk_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             slow_clk,
    input  logic             sw_run,
    input  logic             btn_step,
    input  logic             btn_resume,
    input  logic             halt_req,
    output logic             cpu_en,
    output logic             halted,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_count
);

    logic   slow_sync1_q;
    logic   slow_sync2_q;
    logic   slow_d_q;
    logic   tick;
    logic   step_press;
    logic   resume_press;
    state_t state_q;
    state_t state_d;
    logic   cpu_en_q;
    logic   cpu_en_d;
    logic   halted_q;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_step_deb (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_step),
        .press (step_press)
    );

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_resume_deb (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_resume),
        .press (resume_press)
    );

    assign tick = slow_sync2_q & ~slow_d_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            slow_sync1_q <= 1'b0;
            slow_sync2_q <= 1'b0;
            slow_d_q     <= 1'b0;
        end else begin
            slow_sync1_q <= slow_clk;
            slow_sync2_q <= slow_sync1_q;
            slow_d_q     <= slow_sync2_q;
        end
    end

    // halt_req outranks mode changes, which outrank advance pulses; losers are dropped.
    always_comb begin
        state_d  = state_q;
        cpu_en_d = 1'b0;
        case (state_q)
            ST_STEP: begin
                if (halt_req)    state_d  = ST_HALT;
                else if (sw_run) state_d  = ST_RUN;
                else             cpu_en_d = step_press;
            end
            ST_RUN: begin
                if (halt_req)     state_d  = ST_HALT;
                else if (!sw_run) state_d  = ST_STEP;
                else              cpu_en_d = tick;
            end
            ST_HALT: begin
                if (resume_press && !halt_req) state_d = sw_run ? ST_RUN : ST_STEP;
            end
            default: state_d = ST_STEP;
        endcase
        // A step pulse followed by a tick across a mode switch must not merge.
        if (cpu_en_q) cpu_en_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_STEP;
            cpu_en_q <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cpu_en_q <= cpu_en_d;
            halted_q <= (state_d == ST_HALT);
        end
    end

`ifdef CPU_CLK_CTRL_CYCLE_CNT_EN
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset)         count_q <= '0;
        else if (cpu_en_q) count_q <= count_q + CNT_W'(1);
    end

    assign cycle_count = count_q;
`else
    assign cycle_count = '0;
`endif

    assign cpu_en = cpu_en_q;
    assign halted = halted_q;
    assign state  = state_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Scoreboard bench for cpu_clk_ctrl: expected cpu_en windows are queued as stimulus is driven
// and consumed by a negedge monitor; status and cycle_count are checked at phase boundaries.
module tb_cpu_clk_ctrl;

    localparam int unsigned DEB = 4;
    localparam int unsigned CW  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          slow_clk;
    logic          sw_run;
    logic          btn_step;
    logic          btn_resume;
    logic          halt_req;
    logic          cpu_en;
    logic          halted;
    logic [1:0]    state;
    logic [CW-1:0] cycle_count;

    cpu_clk_ctrl #(
        .DEB_CYCLES (DEB),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .slow_clk    (slow_clk),
        .sw_run      (sw_run),
        .btn_step    (btn_step),
        .btn_resume  (btn_resume),
        .halt_req    (halt_req),
        .cpu_en      (cpu_en),
        .halted      (halted),
        .state       (state),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int lo;
        int hi;
    } win_t;

    win_t exp_q[$];
    win_t w;
    int   n_vec     = 0;
    int   n_err     = 0;
    int   model_cnt = 0;
    logic prev_en   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] exp_count();
`ifdef CPU_CLK_CTRL_CYCLE_CNT_EN
        return 32'(model_cnt % (1 << CW));
`else
        return 32'd0;
`endif
    endfunction

    // Monitor: every cpu_en must land inside the oldest outstanding window.
    always @(negedge clk) begin
        if (cpu_en === 1'b1) begin
            chk("en_consecutive", 32'(prev_en), 0);
            if (exp_q.size() == 0) begin
                chk("en_unexpected", 32'(cpu_en), 0);
            end else begin
                w = exp_q.pop_front();
                chk("en_window", 32'(cyc >= w.lo && cyc <= w.hi), 1);
            end
        end
        prev_en = cpu_en;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_en(input int lo, input int hi);
        exp_q.push_back('{lo, hi});
        model_cnt++;
    endtask

    task automatic slow_period(input bit expect_pulse);
        slow_clk = 1'b1;
        if (expect_pulse) expect_en(cyc + 3, cyc + 3);
        tick(10);
        slow_clk = 1'b0;
        tick(10);
    endtask

    task automatic press_step();
        btn_step = 1'b1;
        tick(1);
        btn_step = 1'b0;
        tick(1);
        btn_step = 1'b1;
        expect_en(cyc + DEB, cyc + DEB + 6);
        tick(10);
        btn_step = 1'b0;
        tick(12);
    endtask

    task automatic press_resume();
        btn_resume = 1'b1;
        tick(10);
        btn_resume = 1'b0;
        tick(12);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        model_cnt = 0;
        exp_q.delete();
    endtask

    initial begin
        reset      = 1'b1;
        slow_clk   = 1'b0;
        sw_run     = 1'b0;
        btn_step   = 1'b0;
        btn_resume = 1'b0;
        halt_req   = 1'b0;
        tick(3);
        @(negedge clk);
        chk("rst_state", 32'(state), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_cpu_en", 32'(cpu_en), 0);
        chk("rst_count", 32'(cycle_count), exp_count());
        tick(1);
        reset = 1'b0;

        // Free-run from slow_clk ticks
        sw_run = 1'b1;
        tick(1);
        @(negedge clk);
        chk("run_state", 32'(state), 1);
        tick(1);
        repeat (5) slow_period(1'b1);
        @(negedge clk);
        chk("run_count", 32'(cycle_count), exp_count());
        chk("run_pending", 32'(exp_q.size()), 0);

        // Single-step with a bouncing button
        tick(1);
        sw_run = 1'b0;
        tick(1);
        @(negedge clk);
        chk("step_state", 32'(state), 0);
        tick(1);
        press_step();
        @(negedge clk);
        chk("step_count", 32'(cycle_count), exp_count());
        chk("step_pending", 32'(exp_q.size()), 0);

        // halt_req coincident with a tick suppresses it
        tick(1);
        sw_run = 1'b1;
        tick(1);
        slow_clk = 1'b1;
        tick(2);
        halt_req = 1'b1;
        tick(1);
        @(negedge clk);
        chk("halt_state", 32'(state), 2);
        chk("halt_halted", 32'(halted), 1);
        tick(8);
        slow_clk = 1'b0;
        tick(10);
        slow_period(1'b0);
        slow_period(1'b0);
        @(negedge clk);
        chk("halt_count", 32'(cycle_count), exp_count());

        // Resume ignored while halt_req is held, then honoured
        tick(1);
        press_resume();
        @(negedge clk);
        chk("resume_blocked", 32'(state), 2);
        tick(1);
        halt_req = 1'b0;
        sw_run   = 1'b0;
        press_resume();
        @(negedge clk);
        chk("resume_state", 32'(state), 0);
        chk("resume_halted", 32'(halted), 0);

        // Counter wrap: 17 pulses into a 4-bit counter
        tick(1);
        do_reset();
        @(negedge clk);
        chk("wrap_rst_count", 32'(cycle_count), exp_count());
        tick(1);
        sw_run = 1'b1;
        tick(1);
        repeat (17) slow_period(1'b1);
        @(negedge clk);
        chk("wrap_count", 32'(cycle_count), exp_count());
        chk("wrap_pending", 32'(exp_q.size()), 0);

        // Reset in the middle of a step debounce
        tick(1);
        sw_run = 1'b0;
        tick(1);
        btn_step = 1'b1;
        tick(2);
        reset    = 1'b1;
        btn_step = 1'b0;
        tick(2);
        reset     = 1'b0;
        model_cnt = 0;
        @(negedge clk);
        chk("abort_state", 32'(state), 0);
        chk("abort_cpu_en", 32'(cpu_en), 0);
        chk("abort_count", 32'(cycle_count), exp_count());
        tick(15);
        @(negedge clk);
        chk("abort_pending", 32'(exp_q.size()), 0);
        chk("abort_count_end", 32'(cycle_count), exp_count());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_clk_ctrl.md
CPU_CLK_CTRL -- requirements
Module: cpu_clk_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 500000: number of consecutive stable clk cycles a button must hold before its level is accepted.
REQ-002 Parameter CNT_W, default 32: width of cycle_count.
REQ-003 clk  in  1  system clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 slow_clk  in  1  divided clock from the frequency divider, asynchronous to this logic.
REQ-006 sw_run  in  1  mode switch: 1 = free-run, 0 = single-step.
REQ-007 btn_step  in  1  raw step push-button, active-high, bouncing.
REQ-008 btn_resume  in  1  raw resume push-button, active-high, bouncing.
REQ-009 halt_req  in  1  level from CPU: halt instruction retired.
REQ-010 cpu_en  out  1  one-clk-cycle CPU advance pulse.
REQ-011 halted  out  1  high while in state HALT.
REQ-012 state  out  2  current FSM state encoding.
REQ-013 cycle_count  out  CNT_W  number of cpu_en pulses issued.

Function
REQ-014 slow_clk SHALL pass through a 2-flop synchronizer; an edge register SHALL form tick = sync & ~sync_d, so tick is high for exactly one clk cycle, during the 3rd clk cycle after slow_clk rises.
REQ-015 btn_step and btn_resume SHALL each be synchronized and debounced; a press pulse SHALL be one clk cycle wide, issued when the debounced level goes 0->1.
REQ-016 A debounced level SHALL change only after the synchronized input differs from it for DEB_CYCLES consecutive cycles; any mismatch-free cycle restarts the count.
REQ-017 FSM states SHALL be STEP=2'd0, RUN=2'd1, HALT=2'd2; 2'd3 is illegal and SHALL transition to STEP.
REQ-018 In STEP: cpu_en = step press pulse; sw_run=1 SHALL move to RUN; halt_req=1 SHALL move to HALT.
REQ-019 In RUN: cpu_en = tick; sw_run=0 SHALL move to STEP; halt_req=1 SHALL move to HALT.
REQ-020 In HALT: cpu_en = 0; a resume press pulse with halt_req=0 SHALL move to RUN if sw_run=1, else STEP; a resume pulse with halt_req=1 SHALL be ignored.
REQ-021 Priority each cycle: halt_req > mode change > advance pulse; a suppressed tick or step pulse SHALL be dropped, not queued.
REQ-022 cpu_en SHALL be registered and never high in two consecutive cycles.
REQ-023 cycle_count SHALL increment by 1 on each cycle with cpu_en=1, wrapping from 2^CNT_W-1 to 0.
REQ-024 halted SHALL equal (state==HALT), registered with state.

Reset
REQ-025 reset SHALL set state=STEP, cpu_en=0, halted=0, cycle_count=0, and clear the synchronizers, edge register, debounce counters and debounced levels.
REQ-026 reset asserted mid-debounce or mid-pulse SHALL abort the operation; no pulse is emitted in the cycle after reset deasserts.

Configuration
REQ-027 Macro CPU_CLK_CTRL_CYCLE_CNT_EN defined: cycle_count is implemented per REQ-023.
REQ-028 Macro undefined: no counter flops; cycle_count is tied to 0; all other behaviour is unchanged.

Structure
REQ-029 Package cpu_clk_ctrl_pkg SHALL hold the state encoding constants (ST_STEP, ST_RUN, ST_HALT) and the default DEB_CYCLES.
REQ-030 Sub-module btn_debounce (synchronizer, counter, level and press pulse, parameter DEB_CYCLES) SHALL be instantiated once per button.

Verification (bench uses DEB_CYCLES=4)
REQ-031 reset, sw_run=1, slow_clk toggling every 10 clk -> cpu_en one cycle wide, 3 clk after each slow_clk rise; cycle_count=5 after 5 rises.
REQ-032 sw_run=0, btn_step bouncing 1/0/1 for 2 cycles then held 1 for 10 cycles -> exactly one cpu_en; cycle_count increments by 1.
REQ-033 RUN, halt_req=1 in the same cycle as tick -> cpu_en stays 0, state=HALT next cycle, halted=1; further slow_clk edges give no cpu_en.
REQ-034 HALT with halt_req=1, resume press -> stays HALT; then halt_req=0, resume press, sw_run=0 -> state=STEP.
REQ-035 With CNT_W=4, issue 17 pulses -> cycle_count=1; without the macro -> cycle_count=0 throughout.
REQ-036 reset asserted 2 cycles into a step debounce -> no cpu_en; state=STEP, cycle_count=0.
